// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//   Top-level controller for Flappy Bricks. It owns the IDLE/PLAY/OVER state
//   machine and the free-running tick that paces motion. It also debounces
//   the jump button, ramps pipe speed during play and keeps the BCD score.
//
//   Ports:
//     clk        system clock
//     rst        synchronous, active-high reset
//     up         raw jump button (asynchronous)
//     pass       datapath level, high while the bird clears a pipe
//     hit        datapath level, collision / floor contact
//     tick       one-clk pulse every TICK_DIV cycles
//     flap       one-clk pulse on an accepted press (IDLE->PLAY or in PLAY)
//     game_run   high in PLAY
//     game_over  high in OVER
//     speed      pipe step per tick
//     score      two-digit BCD score
//     hiscore    BCD best score
//
//   Build option: define GAME_SEQ_HISCORE_EN to keep a best-score register.
//   Without it, hiscore is tied to 0x00.
// ---------------------------------------------------------------------------
module game_sequencer #(
   parameter int         TICK_DIV    = 1048576,
   parameter int         DB_CYCLES   = 65536,
   parameter int         LEVEL_TICKS = 512,
   parameter int         OVER_TICKS  = 100,
   parameter logic [3:0] SPEED_INIT  = 4'd8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       pass,
   input  logic       hit,
   output logic       tick,
   output logic       flap,
   output logic       game_run,
   output logic       game_over,
   output logic [3:0] speed,
   output logic [7:0] score,
   output logic [7:0] hiscore
);

   localparam int TW  = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
   localparam int DBW = (DB_CYCLES   > 1) ? $clog2(DB_CYCLES)   : 1;
   localparam int LW  = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
   localparam int OW  = $clog2(OVER_TICKS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t state, state_nxt;

   // ---------------- button path ----------------
   logic           up_s1, up_s2, up_db, up_db_d;
   logic [DBW-1:0] db_cnt;
   logic           press;

   // db_cnt counts consecutive synchronized samples that disagree with
   // up_db; any agreeing sample restarts the run.
   always_ff @(posedge clk) begin
      if (rst) begin
         up_s1   <= 1'b0;
         up_s2   <= 1'b0;
         up_db   <= 1'b0;
         up_db_d <= 1'b0;
         db_cnt  <= '0;
      end else begin
         up_s1   <= up;
         up_s2   <= up_s1;
         up_db_d <= up_db;
         if (up_s2 == up_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
            up_db  <= up_s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press = up_db & ~up_db_d;

   // ---------------- tick ----------------
   logic [TW-1:0] tcnt;

   always_ff @(posedge clk) begin
      if (rst)                           tcnt <= '0;
      else if (tcnt == TW'(TICK_DIV - 1)) tcnt <= '0;
      else                               tcnt <= tcnt + 1'b1;
   end

   assign tick = (tcnt == TW'(TICK_DIV - 1));

   // ---------------- FSM ----------------
   logic [OW-1:0] ocnt;
   logic          over_done;
   logic          start, play_ok, ending;

   assign over_done = (ocnt >= OW'(OVER_TICKS));
   assign start     = (state == IDLE) & press;
   assign play_ok   = (state == PLAY) & ~hit;   // hit pre-empts all PLAY work
   assign ending    = (state == PLAY) &  hit;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (press)             state_nxt = PLAY;
         PLAY:    if (hit)               state_nxt = OVER;
         OVER:    if (press && over_done) state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   assign game_run  = (state == PLAY);
   assign game_over = (state == OVER);

   // ---------------- score / speed / over timer ----------------
   logic          pass_q, pass_rise;
   logic [LW-1:0] lvl;

   assign pass_rise = pass & ~pass_q;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h99)          r = v;
      else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                     r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         pass_q <= 1'b0;
         flap   <= 1'b0;
         score  <= 8'h00;
         speed  <= SPEED_INIT;
         lvl    <= '0;
         ocnt   <= '0;
      end else begin
         // pass_q tracks in every state so a level held into PLAY never scores
         pass_q <= pass;
         flap   <= start | (play_ok & press);
         if (start) begin
            score <= 8'h00;
            speed <= SPEED_INIT;
            lvl   <= '0;
         end else if (play_ok) begin
            if (pass_rise) score <= bcd_inc(score);
            if (tick) begin
               if (lvl == LW'(LEVEL_TICKS - 1)) begin
                  lvl <= '0;
                  if (speed != 4'hF) speed <= speed + 4'd1;
               end else begin
                  lvl <= lvl + 1'b1;
               end
            end
         end
         if (ending)                                   ocnt <= '0;
         else if ((state == OVER) && tick && !over_done) ocnt <= ocnt + 1'b1;
      end
   end

   // ---------------- best score ----------------
`ifdef GAME_SEQ_HISCORE_EN
   logic [7:0] hi_q;

   // Packed BCD orders the same as its value, so a plain compare works.
   always_ff @(posedge clk) begin
      if (rst)                         hi_q <= 8'h00;
      else if (ending && score > hi_q) hi_q <= score;
   end

   assign hiscore = hi_q;
`else
   assign hiscore = 8'h00;
`endif

endmodule
